pcie_tlp_stream_adapter: RTL
============================

PCIE_TLP_STREAM_ADAPTER -- requirements
Module: pcie_tlp_stream_adapter

Interface
REQ-001 Parameter DATA_W, default 256, meaning stream data width in bits; legal values 128, 256, 512.
REQ-002 Parameter CHANNEL_W, default 8, meaning width of the ignored TLP TX channel field.
REQ-003 Parameter CNT_W, default 32, meaning width of each statistics counter.
REQ-004 Derived widths: PE_W = log2(DATA_W/64) (PHY empty, 64-bit units); TE_W = log2(DATA_W/32) (TLP empty, 32-bit units).
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 reset_n  in  1  synchronous reset, active-low.
REQ-007 phy_tx_st_{data,startofpacket,endofpacket,error,empty,valid}  out  DATA_W,1,1,1,PE_W,1  Avalon-ST source to the hard IP; ready-latency 0.
REQ-008 phy_tx_st_ready  in  1  hard-IP backpressure.
REQ-009 phy_rx_st_{data,empty,error,startofpacket,endofpacket,valid}  in  DATA_W,PE_W,1,1,1,1  Avalon-ST sink from the hard IP; phy_rx_st_ready out 1.
REQ-010 tlp_rx_st_{data,empty,endofpacket,error,startofpacket,valid}  out  DATA_W,TE_W,1,1,1,1  TLP source; tlp_rx_st_ready in 1.
REQ-011 tlp_tx_st_{data,empty,channel,endofpacket,startofpacket,valid}  in  DATA_W,TE_W,CHANNEL_W,1,1,1  TLP sink; tlp_tx_st_ready out 1; channel accepted from every value and discarded.
REQ-012 stat_clear  in  1  synchronous clear of all counters.
REQ-013 stat_tx_pkts, stat_rx_pkts, stat_rx_drop_beats, stat_rx_frame_errs  out  CNT_W each  statistics.

Function
REQ-014 Each direction SHALL pass through a 2-entry skid buffer; all ready outputs are driven directly from flops (no combinational ready path).
REQ-015 Latency SHALL be exactly 1 cycle from accepted input beat to valid output beat when the output is not stalled.
REQ-016 Sustained throughput SHALL be 1 beat/cycle while downstream ready stays high; no beat is lost or duplicated under any ready pattern.
REQ-017 Upstream ready SHALL deassert only when both skid entries are full; output valid/data/sop/eop/empty/error SHALL hold stable while valid=1 and ready=0.
REQ-018 TX empty mapping: phy_tx_st_empty = tlp_tx_st_empty >> 1 (odd dword counts round down, so a partial qword is sent whole).
REQ-019 RX empty mapping: tlp_rx_st_empty = phy_rx_st_empty << 1.
REQ-020 phy_tx_st_error SHALL be constant 0; empty is significant only on eop beats but is passed through on every beat.
REQ-021 RX framing FSM, states IDLE and IN_PKT, advances only on accepted beats (valid & ready).
REQ-022 IDLE + sop: forward; go IN_PKT unless eop also set (single-beat packet stays IDLE).
REQ-023 IDLE + no sop: beat consumed, not forwarded, stat_rx_drop_beats +1, stay IDLE.
REQ-024 IN_PKT + no sop: forward; eop returns to IDLE.
REQ-025 IN_PKT + sop (missing eop): forward with tlp_rx_st_error forced 1, stat_rx_frame_errs +1, state IN_PKT (IDLE if eop also set).
REQ-026 Otherwise tlp_rx_st_error = phy_rx_st_error.
REQ-027 stat_rx_pkts +1 per forwarded eop beat; stat_tx_pkts +1 per eop beat accepted by the hard IP (phy valid & ready & eop).
REQ-028 Counters wrap modulo 2^CNT_W; stat_clear wins over simultaneous increment (result 0).

Reset
REQ-029 While reset_n=0 at a clock edge: skid buffers empty, all valid outputs 0, all ready outputs 0, FSM IDLE, all counters 0; data/empty/sop/eop/error outputs 0.
REQ-030 First cycle after reset_n rises: ready outputs 1.
REQ-031 Reset mid-packet discards buffered beats; the next RX beat is judged from IDLE.

Verification
REQ-032 TX 3-beat packet, tlp empty 5 on eop, phy ready=1 -> same 3 beats 1 cycle later, phy empty 2 on eop, stat_tx_pkts=1.
REQ-033 RX single beat sop+eop, phy empty 3 -> tlp empty 6, error 0, stat_rx_pkts=1.
REQ-034 RX beat without sop in IDLE, then a 2-beat valid packet -> first beat absent on tlp side, stat_rx_drop_beats=1, packet intact.
REQ-035 RX sop, then sop+eop with no eop between -> second beat out with error=1, stat_rx_frame_errs=1, stat_rx_pkts=1.
REQ-036 Random valid and random ready at 50% over 10000 beats each direction -> scoreboard shows zero loss/duplication; phy_rx_st_ready and tlp_tx_st_ready traced to flops.
REQ-037 stat_clear asserted in the same cycle as an eop -> counter reads 0 next cycle; reset_n low mid-packet -> all valids 0, counters 0.

Source files
------------

// File: rtl/pcie_tlp_stream_adapter.sv
// pcie_tlp_stream_adapter: bridges TLP-level Avalon-ST streams to/from the PCIe hard IP, with RX framing checks and statistics.
// Latency: 1 cycle from accepted input beat to output beat in each direction when the output is not stalled.
// Backpressure: each direction has a 2-entry skid buffer; upstream ready is a flop that drops only when both entries are full.
//
// Ports:
//   clk, reset_n                       sole clock, synchronous active-low reset
//   tlp_tx_st_* -> phy_tx_st_*         TX path; empty converted from 32-bit to 64-bit units, channel discarded
//   phy_rx_st_* -> tlp_rx_st_*         RX path; empty converted from 64-bit to 32-bit units, framing enforced
//   stat_clear, stat_*                 synchronous counter clear and wrap-around statistics counters

// Two-entry skid buffer: an output register plus one overflow register.
// Ready is registered and computed from the next-state occupancy, so it never
// depends combinationally on in_vld or out_rdy.
module pcie_tlp_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         rdy_q;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         in_fire;
  logic         out_free;

  assign in_fire  = in_vld & rdy_q;
  // Output register can take a new beat if it is empty or being drained now.
  assign out_free = ~out_vld_q | out_rdy;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free) begin
      if (skid_vld_q) begin
        // Overflow entry is older than anything on the input; it goes first.
        // rdy_q is low whenever skid_vld_q is set, so no input beat arrives here.
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) begin
          out_dat_d = in_dat;
        end
      end
    end else if (in_fire) begin
      // Output stalled: park the beat accepted on the strength of last cycle's ready.
      skid_vld_d = 1'b1;
      skid_dat_d = in_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      rdy_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign in_rdy  = rdy_q;
  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;

endmodule

module pcie_tlp_stream_adapter #(
  parameter int DATA_W    = 256,
  parameter int CHANNEL_W = 8,
  parameter int CNT_W     = 32,
  localparam int PE_W     = $clog2(DATA_W / 64),
  localparam int TE_W     = $clog2(DATA_W / 32)
) (
  input  logic                 clk,
  input  logic                 reset_n,

  // TX: hard-IP side source
  output logic [DATA_W-1:0]    phy_tx_st_data,
  output logic                 phy_tx_st_startofpacket,
  output logic                 phy_tx_st_endofpacket,
  output logic                 phy_tx_st_error,
  output logic [PE_W-1:0]      phy_tx_st_empty,
  output logic                 phy_tx_st_valid,
  input  logic                 phy_tx_st_ready,

  // RX: hard-IP side sink
  input  logic [DATA_W-1:0]    phy_rx_st_data,
  input  logic [PE_W-1:0]      phy_rx_st_empty,
  input  logic                 phy_rx_st_error,
  input  logic                 phy_rx_st_startofpacket,
  input  logic                 phy_rx_st_endofpacket,
  input  logic                 phy_rx_st_valid,
  output logic                 phy_rx_st_ready,

  // RX: TLP side source
  output logic [DATA_W-1:0]    tlp_rx_st_data,
  output logic [TE_W-1:0]      tlp_rx_st_empty,
  output logic                 tlp_rx_st_endofpacket,
  output logic                 tlp_rx_st_error,
  output logic                 tlp_rx_st_startofpacket,
  output logic                 tlp_rx_st_valid,
  input  logic                 tlp_rx_st_ready,

  // TX: TLP side sink
  input  logic [DATA_W-1:0]    tlp_tx_st_data,
  input  logic [TE_W-1:0]      tlp_tx_st_empty,
  input  logic [CHANNEL_W-1:0] tlp_tx_st_channel,
  input  logic                 tlp_tx_st_endofpacket,
  input  logic                 tlp_tx_st_startofpacket,
  input  logic                 tlp_tx_st_valid,
  output logic                 tlp_tx_st_ready,

  // Statistics
  input  logic                 stat_clear,
  output logic [CNT_W-1:0]     stat_tx_pkts,
  output logic [CNT_W-1:0]     stat_rx_pkts,
  output logic [CNT_W-1:0]     stat_rx_drop_beats,
  output logic [CNT_W-1:0]     stat_rx_frame_errs
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [PE_W-1:0]   empty;
    logic              sop;
    logic              eop;
  } tx_beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [TE_W-1:0]   empty;
    logic              err;
    logic              sop;
    logic              eop;
  } rx_beat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } rx_state_t;

  // ---------------------------------------------------------------- TX path
  tx_beat_t tx_in, tx_out;

  // Dropping the low dword bit rounds an odd dword count down, so a partially
  // filled qword is still sent whole.
  assign tx_in.dat   = tlp_tx_st_data;
  assign tx_in.empty = tlp_tx_st_empty[TE_W-1:1];
  assign tx_in.sop   = tlp_tx_st_startofpacket;
  assign tx_in.eop   = tlp_tx_st_endofpacket;

  pcie_tlp_skid #(.W($bits(tx_beat_t))) u_tx_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (tlp_tx_st_valid),
    .in_rdy  (tlp_tx_st_ready),
    .in_dat  (tx_in),
    .out_vld (phy_tx_st_valid),
    .out_rdy (phy_tx_st_ready),
    .out_dat (tx_out)
  );

  assign phy_tx_st_data          = tx_out.dat;
  assign phy_tx_st_empty         = tx_out.empty;
  assign phy_tx_st_startofpacket = tx_out.sop;
  assign phy_tx_st_endofpacket   = tx_out.eop;
  assign phy_tx_st_error         = 1'b0;

  // Channel is accepted on every value and has no effect; the low empty bit is
  // folded away by the qword conversion.
  logic unused_tx_fields;
  assign unused_tx_fields = ^{tlp_tx_st_channel, tlp_tx_st_empty[0]};

  // ---------------------------------------------------------------- RX path
  rx_state_t rx_state_q, rx_state_d;
  logic      rx_acc;
  logic      rx_fwd;
  logic      rx_err;
  logic      rx_drop;
  logic      rx_ferr;
  rx_beat_t  rx_in, rx_out;

  assign rx_acc = phy_rx_st_valid & phy_rx_st_ready;

  // Framing only looks at beats actually taken from the hard IP.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_fwd     = 1'b0;
    rx_err     = phy_rx_st_error;
    rx_drop    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_acc) begin
          if (phy_rx_st_startofpacket) begin
            rx_fwd = 1'b1;
            if (!phy_rx_st_endofpacket) begin
              rx_state_d = IN_PKT;
            end
          end else begin
            // Orphan beat with no packet open: swallow it.
            rx_drop = 1'b1;
          end
        end
      end
      IN_PKT: begin
        if (rx_acc) begin
          rx_fwd = 1'b1;
          if (phy_rx_st_startofpacket) begin
            // Previous packet never saw eop; flag the new start as errored
            // and treat it as the beginning of the next packet.
            rx_err  = 1'b1;
            rx_ferr = 1'b1;
          end
          if (phy_rx_st_endofpacket) begin
            rx_state_d = IDLE;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  assign rx_in.dat   = phy_rx_st_data;
  assign rx_in.empty = {phy_rx_st_empty, 1'b0};
  assign rx_in.err   = rx_err;
  assign rx_in.sop   = phy_rx_st_startofpacket;
  assign rx_in.eop   = phy_rx_st_endofpacket;

  // rx_fwd already includes the accept handshake, and the skid's ready is a
  // flop, so there is no combinational loop through phy_rx_st_ready.
  pcie_tlp_skid #(.W($bits(rx_beat_t))) u_rx_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .in_vld  (rx_fwd),
    .in_rdy  (phy_rx_st_ready),
    .in_dat  (rx_in),
    .out_vld (tlp_rx_st_valid),
    .out_rdy (tlp_rx_st_ready),
    .out_dat (rx_out)
  );

  assign tlp_rx_st_data          = rx_out.dat;
  assign tlp_rx_st_empty         = rx_out.empty;
  assign tlp_rx_st_error         = rx_out.err;
  assign tlp_rx_st_startofpacket = rx_out.sop;
  assign tlp_rx_st_endofpacket   = rx_out.eop;

  // ---------------------------------------------------------------- statistics
  logic tx_pkt_inc;
  logic rx_pkt_inc;

  assign tx_pkt_inc = phy_tx_st_valid & phy_tx_st_ready & phy_tx_st_endofpacket;
  // RX packets are counted as the eop beat is forwarded into the buffer.
  assign rx_pkt_inc = rx_fwd & phy_rx_st_endofpacket;

  // Clear takes priority over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n || stat_clear) begin
      stat_tx_pkts       <= '0;
      stat_rx_pkts       <= '0;
      stat_rx_drop_beats <= '0;
      stat_rx_frame_errs <= '0;
    end else begin
      if (tx_pkt_inc) stat_tx_pkts       <= stat_tx_pkts       + CNT_W'(1);
      if (rx_pkt_inc) stat_rx_pkts       <= stat_rx_pkts       + CNT_W'(1);
      if (rx_drop)    stat_rx_drop_beats <= stat_rx_drop_beats + CNT_W'(1);
      if (rx_ferr)    stat_rx_frame_errs <= stat_rx_frame_errs + CNT_W'(1);
    end
  end

endmodule
